// File: rtl/panel_pkg.sv
// rtl/panel_pkg.sv - shared encodings for the panel switch controller
package panel_pkg;

   typedef enum logic [1:0] {
      ACT_RELEASE = 2'd0,
      ACT_UP      = 2'd1,
      ACT_DOWN    = 2'd2,
      ACT_MOVE    = 2'd3
   } action_e;

   typedef enum logic [1:0] {
      AUX_CENTRE = 2'd0,
      AUX_UP     = 2'd1,
      AUX_DOWN   = 2'd2
   } aux_pos_e;

   localparam int       MOM_BASE    = 18;
   localparam int       MOM_COUNT   = 5;
   localparam aux_pos_e AUX_DEFAULT = AUX_CENTRE;

   // Command word: which momentary switch (offset from MOM_BASE) and its direction.
   typedef struct packed {
      logic [2:0] offset;
      logic       dir;
   } cmd_t;

   localparam int CMD_W = $bits(cmd_t);

   function automatic cmd_t make_cmd(input logic [2:0] offset, input logic dir);
      cmd_t c;
      c.offset = offset;
      c.dir    = dir;
      return c;
   endfunction

   function automatic aux_pos_e aux_from_action(input action_e act);
      aux_pos_e p;
      p = AUX_DEFAULT;
      case (act)
         ACT_UP:   p = AUX_UP;
         ACT_DOWN: p = AUX_DOWN;
         default:  p = AUX_CENTRE;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/panel_cmd_fifo.sv
// rtl/panel_cmd_fifo.sv - command queue that drops pushes when full and flags it
module panel_cmd_fifo #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             s_tvalid,
   input  logic [WIDTH-1:0] s_tdata,
   output logic             m_tvalid,
   output logic [WIDTH-1:0] m_tdata,
   input  logic             m_tready,
   output logic             overflow
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             full;
   logic             empty;
   logic             pop;
   logic             accept;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign empty  = (wr_ptr == rd_ptr);
   assign full   = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign pop    = m_tvalid && m_tready;
   assign accept = s_tvalid && (!full || pop);

   assign m_tvalid = !empty;
   assign m_tdata  = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
      end else begin
         if (accept)
            wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
         if (pop)
            rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
         if (s_tvalid && full && !pop)
            overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (accept)
         mem[wr_ptr[AW-1:0]] <= s_tdata;
   end

endmodule

// File: rtl/panel_switch_ctrl.sv
// rtl/panel_switch_ctrl.sv - cursor-driven panel switch state and momentary command queue
module panel_switch_ctrl
   import panel_pkg::*;
#(
   parameter int SWITCHES_ST_COUNT      = 18,
   parameter int SWITCHES_ST_AUX1_INDEX = 23,
   parameter int SWITCHES_ST_AUX2_INDEX = 24,
   parameter int CMD_FIFO_DEPTH         = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [4:0]                   cursor_index,
   input  logic [1:0]                   cursor_action,
   output logic [SWITCHES_ST_COUNT-1:0] toggle_sw,
   output logic [1:0]                   aux1_pos,
   output logic [1:0]                   aux2_pos,
   output logic [MOM_COUNT-1:0]         mom_held,
   output logic                         cmd_valid,
   output logic [CMD_W-1:0]             cmd,
   input  logic                         cmd_ready,
   output logic                         cmd_overflow
);

   localparam logic [4:0] AUX1_IDX = 5'(SWITCHES_ST_AUX1_INDEX);
   localparam logic [4:0] AUX2_IDX = 5'(SWITCHES_ST_AUX2_INDEX);
   localparam logic [4:0] MOM_LO   = 5'(MOM_BASE);
   localparam logic [4:0] MOM_HI   = 5'(MOM_BASE + MOM_COUNT - 1);

   logic [4:0] idx_r;
   action_e    act_r;
   action_e    act_prev;
   logic [4:0] held_idx;

   logic       evt;
   logic       mom_hit;
   logic       is_press;
   logic [2:0] mom_off;
   logic       push;
   cmd_t       push_cmd;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx_r    <= '0;
         act_r    <= ACT_RELEASE;
         act_prev <= ACT_RELEASE;
      end else begin
         idx_r    <= cursor_index;
         act_r    <= action_e'(cursor_action);
         act_prev <= act_r;
      end
   end

   // Only a change of the registered action is an event; a steady action is ignored.
   assign evt      = (act_r != act_prev);
   assign mom_hit  = (idx_r >= MOM_LO) && (idx_r <= MOM_HI);
   assign is_press = (act_r == ACT_UP) || (act_r == ACT_DOWN);
   assign mom_off  = 3'(idx_r - MOM_LO);
   assign push     = evt && mom_hit && is_press;
   assign push_cmd = make_cmd(mom_off, act_r == ACT_UP);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         toggle_sw <= '0;
         aux1_pos  <= AUX_DEFAULT;
         aux2_pos  <= AUX_DEFAULT;
         mom_held  <= '0;
         held_idx  <= '0;
      end else begin
         // Leaving the held momentary switch releases it; a press below may override.
         if ((mom_held != '0) && (idx_r != held_idx))
            mom_held <= '0;

         if (evt) begin
            for (int i = 0; i < SWITCHES_ST_COUNT; i++) begin
               if (idx_r == 5'(i)) begin
                  if (act_r == ACT_UP)
                     toggle_sw[i] <= 1'b1;
                  else if (act_r == ACT_DOWN)
                     toggle_sw[i] <= 1'b0;
               end
            end

            if ((idx_r == AUX1_IDX) && (act_r != ACT_MOVE))
               aux1_pos <= aux_from_action(act_r);
            if ((idx_r == AUX2_IDX) && (act_r != ACT_MOVE))
               aux2_pos <= aux_from_action(act_r);

            if (!is_press) begin
               mom_held <= '0;
            end else if (mom_hit) begin
               mom_held <= MOM_COUNT'(1) << mom_off;
               held_idx <= idx_r;
            end
         end
      end
   end

   panel_cmd_fifo #(
      .WIDTH (CMD_W),
      .DEPTH (CMD_FIFO_DEPTH)
   ) u_cmd_fifo (
      .clk      (clk),
      .reset    (reset),
      .s_tvalid (push),
      .s_tdata  (push_cmd),
      .m_tvalid (cmd_valid),
      .m_tdata  (cmd),
      .m_tready (cmd_ready),
      .overflow (cmd_overflow)
   );

endmodule

// File: tb/tb_panel_switch_ctrl.sv
// tb/tb_panel_switch_ctrl.sv - directed self-checking bench for panel_switch_ctrl
module tb_panel_switch_ctrl;

   logic        clk;
   logic        reset;
   logic [4:0]  cursor_index;
   logic [1:0]  cursor_action;
   logic [17:0] toggle_sw;
   logic [1:0]  aux1_pos;
   logic [1:0]  aux2_pos;
   logic [4:0]  mom_held;
   logic        cmd_valid;
   logic [3:0]  cmd;
   logic        cmd_ready;
   logic        cmd_overflow;

   int n_tests = 0;
   int n_fail  = 0;

   panel_switch_ctrl dut (
      .clk           (clk),
      .reset         (reset),
      .cursor_index  (cursor_index),
      .cursor_action (cursor_action),
      .toggle_sw     (toggle_sw),
      .aux1_pos      (aux1_pos),
      .aux2_pos      (aux2_pos),
      .mom_held      (mom_held),
      .cmd_valid     (cmd_valid),
      .cmd           (cmd),
      .cmd_ready     (cmd_ready),
      .cmd_overflow  (cmd_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic press(input logic [4:0] idx, input logic [1:0] act);
      cursor_index  = idx;
      cursor_action = act;
      tick(2);
   endtask

   initial begin
      logic [4:0] seq_idx [5];
      logic [1:0] seq_act [5];
      logic [3:0] exp_a [4];
      logic [3:0] exp_b [4];
      seq_idx = '{5'd18, 5'd19, 5'd18, 5'd19, 5'd18};
      seq_act = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd1};
      exp_a   = '{4'b0001, 4'b0010, 4'b0001, 4'b0010};
      exp_b   = '{4'b0010, 4'b0001, 4'b0010, 4'b0101};

      reset = 1'b1; cursor_index = '0; cursor_action = '0; cmd_ready = 1'b0;
      tick(2);
      chk("rst_toggle", toggle_sw, 0);
      chk("rst_aux1", aux1_pos, 0);
      chk("rst_aux2", aux2_pos, 0);
      chk("rst_mom", mom_held, 0);
      chk("rst_valid", cmd_valid, 0);
      chk("rst_ovf", cmd_overflow, 0);
      reset = 1'b0;
      tick(2);

      // toggle switch 5: latency, set, clear, release leaves it alone
      press(5'd5, 2'd3);
      chk("tog_move", toggle_sw, 0);
      cursor_action = 2'd1;
      tick(1);
      chk("tog_latency", toggle_sw, 0);
      tick(1);
      chk("tog_set", toggle_sw, 18'h00020);
      press(5'd5, 2'd2);
      chk("tog_clr", toggle_sw, 0);
      press(5'd5, 2'd1);
      chk("tog_set2", toggle_sw, 18'h00020);
      press(5'd5, 2'd0);
      chk("tog_release", toggle_sw, 18'h00020);

      // momentary 20 down with ready high: single command pulse
      cmd_ready = 1'b1;
      press(5'd20, 2'd3);
      chk("mom_move", mom_held, 0);
      chk("mom_move_valid", cmd_valid, 0);
      press(5'd20, 2'd2);
      chk("mom20_held", mom_held, 5'b00100);
      chk("mom20_valid", cmd_valid, 1);
      chk("mom20_cmd", cmd, 4'b0100);
      tick(1);
      chk("mom20_pulse", cmd_valid, 0);
      press(5'd20, 2'd0);
      chk("mom20_rel", mom_held, 0);
      chk("mom20_rel_nocmd", cmd_valid, 0);

      // cursor leaving the held switch releases it without an event
      press(5'd19, 2'd1);
      chk("mom19_held", mom_held, 5'b00010);
      cursor_index = 5'd5;
      tick(2);
      chk("mom_moveoff", mom_held, 0);
      chk("moveoff_tog", toggle_sw, 18'h00020);

      // overflow: five presses with ready low
      press(5'd5, 2'd0);
      cmd_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         press(seq_idx[i], seq_act[i]);
         if (i == 3) chk("ovf_at4", cmd_overflow, 0);
      end
      chk("ovf_set", cmd_overflow, 1);
      chk("ovf_valid", cmd_valid, 1);
      chk("ovf_head", cmd, 4'b0001);
      chk("ovf_mom", mom_held, 5'b00001);
      tick(3);
      chk("stall_valid", cmd_valid, 1);
      chk("stall_head", cmd, 4'b0001);
      cmd_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("drain_a_valid", cmd_valid, 1);
         chk("drain_a_cmd", cmd, exp_a[i]);
         tick(1);
      end
      chk("drain_a_empty", cmd_valid, 0);
      chk("ovf_sticky", cmd_overflow, 1);

      // full FIFO with a pop on the same edge as a push
      reset = 1'b1; cursor_index = '0; cursor_action = '0; cmd_ready = 1'b0;
      tick(1);
      chk("ovf_cleared", cmd_overflow, 0);
      reset = 1'b0;
      tick(2);
      for (int i = 0; i < 4; i++) press(seq_idx[i], seq_act[i]);
      chk("full_valid", cmd_valid, 1);
      chk("full_ovf", cmd_overflow, 0);
      cursor_index = 5'd20; cursor_action = 2'd1;
      tick(1);
      cmd_ready = 1'b1;
      tick(1);
      cmd_ready = 1'b0;
      chk("fullpop_ovf", cmd_overflow, 0);
      chk("fullpop_head", cmd, 4'b0010);
      cmd_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("drain_b_valid", cmd_valid, 1);
         chk("drain_b_cmd", cmd, exp_b[i]);
         tick(1);
      end
      chk("drain_b_empty", cmd_valid, 0);

      // three-position AUX switches and out-of-range index
      press(5'd23, 2'd0);
      chk("aux1_c0", aux1_pos, 0);
      chk("aux_mom_off", mom_held, 0);
      press(5'd23, 2'd1);
      chk("aux1_up", aux1_pos, 1);
      press(5'd23, 2'd0);
      chk("aux1_centre", aux1_pos, 0);
      press(5'd23, 2'd2);
      chk("aux1_down", aux1_pos, 2);
      press(5'd24, 2'd1);
      chk("aux2_up", aux2_pos, 1);
      chk("aux1_keep", aux1_pos, 2);
      press(5'd24, 2'd3);
      chk("aux2_move", aux2_pos, 1);
      press(5'd27, 2'd1);
      chk("idx27_tog", toggle_sw, 0);
      chk("idx27_aux1", aux1_pos, 2);
      chk("idx27_aux2", aux2_pos, 1);
      chk("idx27_mom", mom_held, 0);
      chk("idx27_valid", cmd_valid, 0);

      // reset mid-operation with commands queued
      cmd_ready = 1'b0;
      press(5'd21, 2'd2);
      press(5'd21, 2'd1);
      chk("pre_rst_mom", mom_held, 5'b01000);
      chk("pre_rst_valid", cmd_valid, 1);
      chk("pre_rst_cmd", cmd, 4'b0110);
      #2;
      reset = 1'b1;
      cursor_action = 2'd0;
      #1;
      chk("arst_aux1", aux1_pos, 0);
      chk("arst_aux2", aux2_pos, 0);
      chk("arst_mom", mom_held, 0);
      chk("arst_valid", cmd_valid, 0);
      chk("arst_tog", toggle_sw, 0);
      tick(1);
      reset = 1'b0;
      cmd_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick(1);
         chk("post_rst_nocmd", cmd_valid, 0);
      end
      chk("post_rst_mom", mom_held, 0);
      chk("post_rst_ovf", cmd_overflow, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/panel_switch_ctrl.md
PANEL_SWITCH_CTRL -- requirements
Module: panel_switch_ctrl

Interface
REQ-001 Parameter SWITCHES_ST_COUNT, default 18: number of latching toggle switches at cursor indices 0..17.
REQ-002 Parameter SWITCHES_ST_AUX1_INDEX, default 23: cursor index of the three-position latched AUX1 switch.
REQ-003 Parameter SWITCHES_ST_AUX2_INDEX, default 24: cursor index of the three-position latched AUX2 switch.
REQ-004 Parameter CMD_FIFO_DEPTH, default 4: command FIFO entries, power of two.
REQ-005 clk  in  1: single clock; all state on rising edge.
REQ-006 reset  in  1: asynchronous, active-high reset.
REQ-007 cursor_index  in  5: currently selected panel switch.
REQ-008 cursor_action  in  2: 0 = release/centre, 1 = up, 2 = down, 3 = cursor move (no switch effect).
REQ-009 toggle_sw  out  18: latched toggle switch positions, 1 = up.
REQ-010 aux1_pos, aux2_pos  out  2 each: 0 = centre, 1 = up, 2 = down.
REQ-011 mom_held  out  5: one-hot held momentary switch, indices 18..22; bit i = index 18+i.
REQ-012 cmd_valid  out  1; cmd  out  4 = {momentary offset[2:0], dir}, dir 1 = up, 0 = down; cmd_ready  in  1.
REQ-013 cmd_overflow  out  1: sticky, set when a command is dropped.

Function
REQ-014 Inputs are registered once; an event occurs when the registered cursor_action differs from its previous registered value; inputs are otherwise ignored.
REQ-015 Effects of an event are visible on the outputs from the 2nd rising edge after the input change.
REQ-016 Event at index < 18: action 1 sets toggle_sw[index]; action 2 clears it; actions 0 and 3 cause no change.
REQ-017 Event at AUX1 or AUX2 index: actions 0, 1 and 2 set the position to 0, 1 and 2 respectively; action 3 causes no change.
REQ-018 Event at indices 18..22 with action 1 or 2 sets mom_held to that index and pushes cmd {index-18, action==1}.
REQ-019 Event with action 0 or 3 clears mom_held; no command is issued on release.
REQ-020 If mom_held is nonzero and the registered cursor_index moves off the held index, mom_held clears on the same edge.
REQ-021 Indices 25..31 cause no effect.
REQ-022 A press while a different momentary switch is held replaces the held switch and issues one new command.
REQ-023 The FIFO holds CMD_FIFO_DEPTH entries; cmd_valid = not empty; cmd shows the head entry; a pop occurs when cmd_valid and cmd_ready are both high.
REQ-024 cmd and cmd_valid are held stable while cmd_ready is low.
REQ-025 When the FIFO is full, a push is dropped and cmd_overflow is set, unless a pop occurs on the same edge; push and pop together when full are both accepted.
REQ-026 Push and pop in the same cycle with the FIFO empty: the push is accepted; cmd_valid rises on the next edge.
REQ-027 FIFO pointers are log2(depth)+1 bits and wrap modulo 2*depth; full = same index with the MSB differing.
REQ-028 cmd_overflow is cleared only by reset.

Reset
REQ-029 Asynchronous assertion of reset clears toggle_sw, aux1_pos, aux2_pos, mom_held, all FIFO pointers, cmd_valid, cmd_overflow and the input/previous registers to 0.
REQ-030 Reset mid-operation discards queued commands; no event is generated by the first cycle after release.

Structure
REQ-031 Package panel_pkg holds the action encodings, momentary index base (18), momentary count (5), AUX defaults and the cmd field layout.
REQ-032 The FIFO is a sub-module panel_cmd_fifo, parameterised by width 4 and depth.

Verification
REQ-033 index 5, action 3→1 → toggle_sw[5]=1 two edges later; action 1→2 → toggle_sw[5]=0; action 0 → unchanged.
REQ-034 index 20, action 3→2 with cmd_ready=1 → mom_held=5'b00100 and one cmd=4'b0100 pulse; action →0 → mom_held=0, no cmd.
REQ-035 cmd_ready=0, five presses alternating index 18/19 → cmd_valid=1, head cmd=4'b0001, cmd_overflow=1 after the 5th; drain yields 4 cmds in order.
REQ-036 FIFO full, cmd_ready=1 while a press occurs → the new cmd is accepted and cmd_overflow stays 0.
REQ-037 index 23 actions 1, 0, 2 → aux1_pos 1, 0, 2; index 27 action 1 → all outputs unchanged.
REQ-038 Hold index 21 up, then assert reset for 1 cycle with 2 cmds queued → all outputs 0 immediately, with no cmd after release.
